// File: rtl/apb_image_loader.sv
// APB2 master that streams one packed-pixel image into the recognizer, fires its
// start register, holds the bus in the compute state and samples the result line.
module apb_image_loader #(
   parameter int unsigned Amba_Word       = 24,
   parameter int unsigned Amba_Addr_Depth = 12,
   parameter int unsigned WordCount       = 4096,
   parameter int unsigned WaitCycles      = 4112
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [Amba_Word-1:0]     pix_data,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic                     PSEL,
   output logic                     PENABLE,
   output logic                     PWRITE,
   output logic [Amba_Addr_Depth:0] PADDR,
   output logic [Amba_Word-1:0]     PWDATA,
   input  logic [Amba_Word-1:0]     PRDATA,
   input  logic                     cat_in,
   output logic                     busy,
   output logic                     result,
   output logic                     result_valid
);

   localparam int unsigned AW  = Amba_Addr_Depth + 1;
   localparam int unsigned WCW = $clog2(WaitCycles + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETUP,
      S_ACCESS,
      S_START_SETUP,
      S_START_ACCESS,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [AW-1:0]    r_word_cnt;
   logic [WCW-1:0]   r_wait_cnt;

   // No reads are issued in this revision.
   logic w_prdata_unused;
   assign w_prdata_unused = ^PRDATA;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= '0;
         r_wait_cnt   <= '0;
         pix_ready    <= 1'b0;
         PSEL         <= 1'b0;
         PENABLE      <= 1'b0;
         PWRITE       <= 1'b0;
         PADDR        <= '0;
         PWDATA       <= '0;
         busy         <= 1'b0;
         result       <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state      <= S_FETCH;
                  busy         <= 1'b1;
                  result_valid <= 1'b0;
                  r_word_cnt   <= AW'(1);
                  pix_ready    <= 1'b1;
               end
            end
            S_FETCH: begin
               if (pix_valid && pix_ready) begin
                  PWDATA    <= pix_data;
                  PADDR     <= r_word_cnt;
                  PWRITE    <= 1'b1;
                  PSEL      <= 1'b1;
                  pix_ready <= 1'b0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               PENABLE <= 1'b0;
               // Last word goes straight into the start-register write, keeping PSEL up.
               if (r_word_cnt == AW'(WordCount)) begin
                  PADDR   <= '0;
                  PWDATA  <= Amba_Word'(1);
                  r_state <= S_START_SETUP;
               end else begin
                  PSEL       <= 1'b0;
                  r_word_cnt <= r_word_cnt + AW'(1);
                  pix_ready  <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end
            S_START_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= S_START_ACCESS;
            end
            S_START_ACCESS: begin
               PENABLE    <= 1'b0;
               PWRITE     <= 1'b0;
               r_wait_cnt <= WCW'(WaitCycles);
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // Selected-but-not-enabled is what lets the slave compute.
               if (r_wait_cnt <= WCW'(1)) begin
                  result       <= cat_in;
                  result_valid <= 1'b1;
                  PSEL         <= 1'b0;
                  busy         <= 1'b0;
                  r_state      <= S_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt - WCW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_image_loader.sv
// Randomized self-checking bench for apb_image_loader: APB write sequence, timing,
// backpressure, ignored starts, result capture, async reset and restart.
module tb_apb_image_loader;

   localparam int WC = 4096;
   localparam int WT = 4112;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [12:0] PADDR;
   logic [23:0] PWDATA;
   logic [23:0] PRDATA;
   logic        cat_in;
   logic        busy;
   logic        result;
   logic        result_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations gathered by load_image
   logic [12:0] obs_addr[$];
   logic [23:0] obs_data[$];
   logic [23:0] acc_data[$];
   int   proto_err, stall_err, wait_err;
   int   t_sa, t_wait, t_rv, t_last;
   bit   timeout;
   logic rv_result, rv_busy, rv_sel;
   logic v0_rv, v0_busy, v0_ready;

   apb_image_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PADDR        (PADDR),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .cat_in       (cat_in),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   // Runs one image from a negedge: mode 0 = valid always high with data = address,
   // mode 1 = random ~1/3 valid with random data. t counts edges after the start edge.
   task automatic load_image(input int mode, input bit cat, input bit poke);
      int          t;
      logic        prev_sel, prev_en;
      logic [12:0] prev_addr;
      logic [23:0] prev_data;
      logic        v;
      logic [23:0] d;
      obs_addr.delete(); obs_data.delete(); acc_data.delete();
      proto_err = 0; stall_err = 0; wait_err = 0;
      t_sa = -1; t_wait = -1; t_rv = -1; t_last = -1; timeout = 0;
      prev_sel = 0; prev_en = 0; prev_addr = '0; prev_data = '0;
      cat_in = cat; pix_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      v0_rv = result_valid; v0_busy = busy; v0_ready = pix_ready;
      while (1) begin
         if (PSEL && PENABLE) begin
            if (!(prev_sel && !prev_en && prev_addr == PADDR && prev_data == PWDATA && PWRITE))
               proto_err++;
            obs_addr.push_back(PADDR);
            obs_data.push_back(PWDATA);
            if (PADDR == 13'd0) t_sa = t;
            else t_last = t;
         end
         if (pix_ready && PSEL) stall_err++;
         if (t_sa >= 0 && t > t_sa && !result_valid) begin
            if (t_wait < 0) t_wait = t;
            if (!(PSEL && !PENABLE && !PWRITE && busy)) wait_err++;
         end
         if (result_valid) begin
            t_rv = t; rv_result = result; rv_busy = busy; rv_sel = PSEL;
            break;
         end
         if (t > 60000) begin
            timeout = 1;
            break;
         end
         v = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         d = (mode == 0) ? 24'(acc_data.size() + 1) : 24'($urandom);
         pix_valid = v;
         pix_data  = d;
         if (pix_ready && v) acc_data.push_back(d);
         start = poke && (t == 4 || (t_sa >= 0 && t == t_sa + 50));
         prev_sel = PSEL; prev_en = PENABLE; prev_addr = PADDR; prev_data = PWDATA;
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      pix_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b want 0", PSEL); end
      n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", PENABLE); end
      n_checks++; if (PWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite: got %b want 0", PWRITE); end
      n_checks++; if (PADDR !== 13'd0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
      n_checks++; if (PWDATA !== 24'd0) begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (result !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %b want 0", result); end
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      int          n;
      bit          hit;
      logic [23:0] first_d;
      logic [23:0] d;
      bit          got_first;
      hit = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 1000; n++) begin
         if (PSEL && PENABLE && PADDR == 13'd100) begin
            hit = 1;
            break;
         end
         pix_valid = 1'b1;
         pix_data  = 24'($urandom);
         @(negedge clk);
      end
      n_checks++; if (!hit) begin n_fail++; $display("FAIL midrst_reach: word 100 access not seen within %0d cycles", n); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL midrst_psel: got %b want 0", PSEL); end
      n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL midrst_penable: got %b want 0", PENABLE); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_pix_ready: got %b want 0", pix_ready); end
      @(negedge clk);
      rst = 1'b1;
      pix_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 0; got_first = 0; first_d = '0;
      for (n = 0; n < 50; n++) begin
         if (PSEL && PENABLE) begin
            hit = 1;
            break;
         end
         d = 24'($urandom);
         if (pix_ready && !got_first) begin first_d = d; got_first = 1; end
         pix_valid = 1'b1;
         pix_data  = d;
         @(negedge clk);
      end
      n_checks++; if (!hit || PADDR !== 13'd1) begin n_fail++; $display("FAIL midrst_restart_addr: got %h (seen=%0d) want 1", PADDR, hit); end
      n_checks++; if (!hit || PWDATA !== first_d) begin n_fail++; $display("FAIL midrst_restart_data: got %h want %h", PWDATA, first_d); end
      pix_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_load();
      int bad;
      logic [12:0] ea;
      logic [23:0] ed;
      load_image(0, 1'b1, 1'b1);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL full_timeout: result_valid never rose"); end
      n_checks++; if (obs_addr.size() != WC + 1) begin n_fail++; $display("FAIL full_count: got %0d writes want %0d", obs_addr.size(), WC + 1); end
      bad = -1;
      for (int i = 0; i < obs_addr.size(); i++) begin
         ea = (i < WC) ? 13'(i + 1) : 13'd0;
         ed = (i < WC) ? 24'(i + 1) : 24'd1;
         if (bad < 0 && (obs_addr[i] !== ea || obs_data[i] !== ed)) bad = i;
      end
      n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL full_seq: write %0d got addr %h data %h", bad, obs_addr[bad], obs_data[bad]); end
      n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL full_protocol: got %0d bad accesses want 0", proto_err); end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL full_psel_in_fetch: got %0d want 0", stall_err); end
      n_checks++; if (wait_err != 0) begin n_fail++; $display("FAIL full_wait_bus: got %0d bad cycles want 0", wait_err); end
      n_checks++; if (t_wait != 3 * WC + 2) begin n_fail++; $display("FAIL full_wait_entry: got %0d want %0d", t_wait, 3 * WC + 2); end
      n_checks++; if (t_sa - t_last != 2) begin n_fail++; $display("FAIL full_start_gap: got %0d want 2", t_sa - t_last); end
      n_checks++; if (t_rv - t_sa != WT + 1) begin n_fail++; $display("FAIL full_result_latency: got %0d want %0d", t_rv - t_sa, WT + 1); end
      n_checks++; if (rv_result !== 1'b1) begin n_fail++; $display("FAIL full_result: got %b want 1", rv_result); end
      n_checks++; if (rv_busy !== 1'b0 || rv_sel !== 1'b0) begin n_fail++; $display("FAIL full_done_bus: busy %b psel %b want 0 0", rv_busy, rv_sel); end
   endtask

   task automatic test_backpressure();
      int bad;
      logic [12:0] ea;
      logic [23:0] ed;
      load_image(1, 1'b0, 1'b1);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout: result_valid never rose"); end
      n_checks++; if (acc_data.size() != WC) begin n_fail++; $display("FAIL bp_accepted: got %0d words want %0d", acc_data.size(), WC); end
      n_checks++; if (obs_addr.size() != acc_data.size() + 1) begin n_fail++; $display("FAIL bp_count: got %0d writes want %0d", obs_addr.size(), acc_data.size() + 1); end
      bad = -1;
      for (int i = 0; i < obs_addr.size(); i++) begin
         ea = (i < acc_data.size()) ? 13'(i + 1) : 13'd0;
         ed = (i < acc_data.size()) ? acc_data[i] : 24'd1;
         if (bad < 0 && (obs_addr[i] !== ea || obs_data[i] !== ed)) bad = i;
      end
      n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL bp_seq: write %0d got addr %h data %h", bad, obs_addr[bad], obs_data[bad]); end
      n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL bp_protocol: got %0d bad accesses want 0", proto_err); end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_psel_in_fetch: got %0d want 0", stall_err); end
      n_checks++; if (wait_err != 0) begin n_fail++; $display("FAIL bp_wait_bus: got %0d bad cycles want 0", wait_err); end
      n_checks++; if (t_rv - t_sa != WT + 1) begin n_fail++; $display("FAIL bp_result_latency: got %0d want %0d", t_rv - t_sa, WT + 1); end
      n_checks++; if (rv_result !== 1'b0) begin n_fail++; $display("FAIL bp_result: got %b want 0", rv_result); end
   endtask

   task automatic test_restart();
      int bad;
      bit c;
      logic [12:0] ea;
      logic [23:0] ed;
      c = 1'($urandom);
      load_image(0, c, 1'b0);
      n_checks++; if (v0_rv !== 1'b0) begin n_fail++; $display("FAIL restart_rv_clear: got %b want 0", v0_rv); end
      n_checks++; if (v0_busy !== 1'b1 || v0_ready !== 1'b1) begin n_fail++; $display("FAIL restart_fetch: busy %b ready %b want 1 1", v0_busy, v0_ready); end
      n_checks++; if (timeout) begin n_fail++; $display("FAIL restart_timeout: result_valid never rose"); end
      n_checks++; if (obs_addr.size() != WC + 1) begin n_fail++; $display("FAIL restart_count: got %0d writes want %0d", obs_addr.size(), WC + 1); end
      bad = -1;
      for (int i = 0; i < obs_addr.size(); i++) begin
         ea = (i < WC) ? 13'(i + 1) : 13'd0;
         ed = (i < WC) ? 24'(i + 1) : 24'd1;
         if (bad < 0 && (obs_addr[i] !== ea || obs_data[i] !== ed)) bad = i;
      end
      n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL restart_seq: write %0d got addr %h data %h", bad, obs_addr[bad], obs_data[bad]); end
      n_checks++; if (t_wait != 3 * WC + 2) begin n_fail++; $display("FAIL restart_wait_entry: got %0d want %0d", t_wait, 3 * WC + 2); end
      n_checks++; if (rv_result !== c) begin n_fail++; $display("FAIL restart_result: got %b want %b", rv_result, c); end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
      cat_in = 1'b0; PRDATA = '0;
      test_reset();
      test_reset_mid_load();
      test_full_load();
      test_backpressure();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_image_loader.md
Name: apb_image_loader

Overview:
- APB2 master that drives the accelerator's APB slave port: streams one image (4096 packed 3-pixel words) from an upstream valid/ready source into slave addresses 1..4096.
- Then writes 1 to the start register at address 0, holds the bus in the compute-enabling state, and samples the accelerator's result line.
- Sits between the image DMA/testbench source and the recognizer; it is the initiator for the recognizer's responder port.

Parameters:
- Amba_Word, 24, APB data width; also the packed pixel-word width (3 x 8-bit pixels).
- Amba_Addr_Depth, 12, PADDR is Amba_Addr_Depth+1 bits wide.
- WordCount, 4096, pixel words per image; written to addresses 1..WordCount.
- WaitCycles, 4112, cycles held in WAIT before sampling the result. Must be >= WordCount+8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to load and classify one image; ignored unless idle
- pix_data  in  Amba_Word  packed pixels, [7:0] first pixel
- pix_valid  in  1  upstream word valid
- pix_ready  out  1  loader accepts word this cycle
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB write
- PADDR  out  Amba_Addr_Depth+1  APB address
- PWDATA  out  Amba_Word  APB write data
- PRDATA  in  Amba_Word  APB read data; unused this revision, no reads issued
- cat_in  in  1  recognizer result line
- busy  out  1  high from accepted start until DONE
- result  out  1  sampled classification, 1 = cat
- result_valid  out  1  high in DONE; cleared by next accepted start

Behaviour:
- Reset (rst=0, async) forces IDLE. All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, pix_ready, busy, result, result_valid. Word counter and wait counter are cleared. Reset mid-transfer aborts immediately; there is no resume.
- All state changes on posedge clk; all outputs are registered.
- IDLE:
  - start=1 -> FETCH; busy<=1; result_valid<=0; word counter<=1.
  - Bus is idle (PSEL=0).
- FETCH:
  - pix_ready=1, PSEL=0.
  - On pix_valid & pix_ready: latch PWDATA<=pix_data, PADDR<=counter, PWRITE<=1 -> SETUP.
  - pix_ready drops in the same edge, so at most one word is accepted per FETCH visit.
  - pix_valid low holds FETCH indefinitely.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA stable -> ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, address and data unchanged. The slave has no PREADY; every access completes in one cycle.
  - Next: if counter==WordCount -> START_SETUP; else counter+1 -> FETCH.
  - PENABLE drops and PSEL drops (PSEL=0 in FETCH).
  - Throughput: 3 cycles per word with pix_valid held high.
- START_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=0, PWDATA=1 (zero-extended) -> START_ACCESS.
- START_ACCESS: PENABLE=1 -> WAIT. Load wait counter with WaitCycles.
- WAIT:
  - PSEL=1, PENABLE=0, PWRITE=0. PADDR and PWDATA hold their last values. The slave advances its computation only while selected and not enabled.
  - Counter decrements each cycle.
  - At 0: result<=cat_in, result_valid<=1 -> DONE.
- DONE:
  - PSEL=0, busy=0, result/result_valid held.
  - start=1 -> FETCH with the same actions as IDLE; this start is accepted.
- start while busy is ignored and has no side effect.
- Counter width is Amba_Addr_Depth+1. WordCount=4096 fits the 13-bit PADDR; the counter never wraps.
- pix_ready is 0 in every state except FETCH.
- pix_valid/pix_data are ignored outside FETCH.

Test Plan:
- Reset mid-load: deassert rst at word 100 in ACCESS -> same cycle (async) PSEL=0, PENABLE=0, busy=0, pix_ready=0. Next start restarts at PADDR=1.
- Full load, pix_valid always 1, words = address value: PADDR 1..4096 with PWDATA = PADDR. Every PENABLE=1 cycle is preceded by a PSEL=1, PENABLE=0 cycle with identical PADDR/PWDATA. Last data write at PADDR=0x1000. Start write PADDR=0, PWDATA=1 two cycles later. 3*4096+2 cycles from start to WAIT.
- Backpressure: pix_valid toggles 1-0-0 repeatedly -> no APB write without an accepted word; addresses stay contiguous; PSEL low during stalls.
- Result capture: cat_in=1 -> result=1 and result_valid=1 exactly WaitCycles+1 cycles after START_ACCESS; PSEL=1, PENABLE=0 throughout WAIT. Repeat with cat_in=0 -> result=0.
- Start ignored while busy: pulse start during FETCH/WAIT -> no counter change, no extra transfer.
- Restart from DONE: start clears result_valid the next cycle, and the second image loads identically.
